// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: slot identifiers, clear-engine states
// and the two-port round-robin pick function.
package vram_pkg;

  typedef enum logic [2:0] {
    SLOT_NONE,
    SLOT_VID,
    SLOT_CLR,
    SLOT_P0,
    SLOT_P1
  } slot_t;

  typedef enum logic {
    C_IDLE,
    C_CLEAR
  } clr_state_t;

  // On a tie the port that did not win last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
    logic [1:0] pick;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational; last_gnt only
// moves when a grant is actually issued.
module rr_arb2
  import vram_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_gnt;

  // NOTE: every variable assigned in always_comb gets a value on all paths,
  // otherwise synthesis infers a latch.
  always_comb begin
    gnt = 2'b00;
    if (en) gnt = rr_pick(req, last_gnt);
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt <= 1'b1;
    end else if (gnt[0]) begin
      last_gnt <= 1'b0;
    end else if (gnt[1]) begin
      last_gnt <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing: video fetch, built-in clear engine and two
// round-robin requesters, one slot per cycle, with registered read steering.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_ce,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rvalid,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'((2 ** ADDR_W) - 1);

  clr_state_t        state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] clear_val_q;
  slot_t             slot;
  slot_t             ret_slot;
  slot_t             slot_q;
  logic              vid_slot;
  logic              clr_slot;
  logic              port_en;

  assign clear_busy = (state == C_CLEAR);
  assign vid_slot   = disp_active & pixel_ce;
  assign clr_slot   = clear_busy & ~vid_slot;
  assign port_en    = ~Reset & ~vid_slot & ~clear_busy;

  rr_arb2 u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (req),
    .en    (port_en),
    .gnt   (gnt)
  );

  always_comb begin
    slot      = SLOT_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (vid_slot) begin
      slot     = SLOT_VID;
      mem_addr = vid_addr;
    end else if (clr_slot) begin
      slot      = SLOT_CLR;
      mem_addr  = clr_cnt[ADDR_W-1:0];
      mem_wdata = clear_val_q;
      mem_we    = 1'b1;
    end else if (gnt[0]) begin
      slot      = SLOT_P0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we[0];
    end else if (gnt[1]) begin
      slot      = SLOT_P1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we[1];
    end
    // A clear slot can still be selected while Reset is high; never let it write.
    if (Reset) mem_we = 1'b0;
  end

  // Only slots that return data are remembered for the next cycle.
  always_comb begin
    ret_slot = slot;
    if ((slot == SLOT_CLR) ||
        ((slot == SLOT_P0) && we[0]) ||
        ((slot == SLOT_P1) && we[1])) begin
      ret_slot = SLOT_NONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= C_IDLE;
      clr_cnt     <= '0;
      clear_val_q <= '0;
      slot_q      <= SLOT_NONE;
    end else begin
      slot_q <= ret_slot;
      unique case (state)
        C_IDLE: begin
          if (clear_start) begin
            state       <= C_CLEAR;
            clr_cnt     <= '0;
            clear_val_q <= clear_value;
          end
        end
        C_CLEAR: begin
          if (clr_slot) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) state <= C_IDLE;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  // The RAM already has one cycle of latency, so returns are steered, not re-registered.
  assign vid_valid = (slot_q == SLOT_VID);
  assign vid_data  = vid_valid ? mem_rdata : '0;
  assign rvalid    = {slot_q == SLOT_P1, slot_q == SLOT_P0};
  assign rdata     = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter (ADDR_W=4): vector table, clear corner
// sequences, and randomized traffic against a slot-level reference model.
module tb_vram_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          Clk = 1'b0;
  logic          Reset, pixel_ce, disp_active, clear_start;
  logic [AW-1:0] vid_addr, addr0, addr1, mem_addr;
  logic [DW-1:0] vid_data, wdata0, wdata1, rdata, clear_value, mem_wdata, mem_rdata;
  logic          vid_valid, clear_busy, mem_we;
  logic [1:0]    req, we, gnt, rvalid;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce), .disp_active(disp_active),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Environment RAM: single port, one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_init = 1'b1;
  always @(posedge Clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic          rst;
    logic          dsp;
    logic          pce;
    logic [AW-1:0] vaddr;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          cs;
    logic [DW-1:0] cv;
  } stim_t;

  typedef struct {
    logic          dsp;
    logic          pce;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [1:0]    e_gnt;
    logic [1:0]    e_rv;
    logic [DW-1:0] e_rd;
    logic          e_vv;
  } vec_t;

  // Reference model: expected RAM image, clear progress, last winner, pending returns.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known = 1'b0;
  bit            m_busy  = 1'b0;
  int            m_caddr = 0;
  logic [DW-1:0] m_cval  = '0;
  int            m_last  = 1;
  logic          m_pv    = 1'b0;
  logic [DW-1:0] m_pvd   = '0;
  logic [1:0]    m_pr    = 2'b00;
  logic [DW-1:0] m_prd   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    Reset = s.rst; disp_active = s.dsp; pixel_ce = s.pce; vid_addr = s.vaddr;
    req = s.req; we = s.we; addr0 = s.a0; addr1 = s.a1; wdata0 = s.d0; wdata1 = s.d1;
    clear_start = s.cs; clear_value = s.cv;
  endtask

  // Checks the current cycle against the model, then advances the model.
  task automatic model_step(input stim_t s);
    logic [1:0]    eg;
    logic          n_pv;
    logic [DW-1:0] n_pvd;
    logic [1:0]    n_pr;
    logic [DW-1:0] n_prd;
    bit            busy_before;
    int            w;
    eg = 2'b00; n_pv = 1'b0; n_pvd = '0; n_pr = 2'b00; n_prd = '0;
    busy_before = m_busy;
    if (m_known) begin
      check("vid_valid", vid_valid, m_pv);
      check("vid_data", vid_data, m_pv ? m_pvd : '0);
      check("rvalid", rvalid, m_pr);
      check("rdata", rdata, (m_pr != 2'b00) ? m_prd : '0);
      check("clear_busy", clear_busy, m_busy);
    end
    if (s.rst) begin
      check("rst_mem_we", mem_we, 1'b0);
    end else if (s.dsp && s.pce) begin
      check("vid_mem_addr", mem_addr, s.vaddr);
      check("vid_mem_we", mem_we, 1'b0);
      n_pv  = 1'b1;
      n_pvd = m_mem[s.vaddr];
    end else if (m_busy) begin
      check("clr_mem_we", mem_we, 1'b1);
      check("clr_mem_addr", mem_addr, m_caddr);
      check("clr_mem_wdata", mem_wdata, m_cval);
      m_mem[m_caddr] = m_cval;
      m_caddr++;
      if (m_caddr == DEPTH) m_busy = 1'b0;
    end else if (s.req != 2'b00) begin
      if (s.req == 2'b11) w = 1 - m_last;
      else                w = s.req[0] ? 0 : 1;
      m_last = w;
      eg[w]  = 1'b1;
      check("port_mem_addr", mem_addr, (w == 0) ? s.a0 : s.a1);
      check("port_mem_we", mem_we, s.we[w]);
      if (s.we[w]) begin
        check("port_mem_wdata", mem_wdata, (w == 0) ? s.d0 : s.d1);
        m_mem[(w == 0) ? s.a0 : s.a1] = (w == 0) ? s.d0 : s.d1;
      end else begin
        n_pr[w] = 1'b1;
        n_prd   = m_mem[(w == 0) ? s.a0 : s.a1];
      end
    end else begin
      check("idle_mem_we", mem_we, 1'b0);
    end
    check("gnt", gnt, eg);
    if (s.rst) begin
      m_busy = 1'b0; m_last = 1; m_known = 1'b1;
      n_pv = 1'b0; n_pr = 2'b00;
    end else if (!busy_before && s.cs) begin
      m_busy = 1'b1; m_caddr = 0; m_cval = s.cv;
    end
    m_pv = n_pv; m_pvd = n_pvd; m_pr = n_pr; m_prd = n_prd;
  endtask

  task automatic finish_cycle(input stim_t s);
    model_step(s);
    @(posedge Clk);
    #1;
  endtask

  task automatic run_cycle(input stim_t s);
    drive(s);
    #3;
    finish_cycle(s);
  endtask

  task automatic readback(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    stim_t s;
    s = idle(); s.req = 2'b01; s.a0 = a;
    drive(s); #3;
    check("rb_gnt", gnt, 2'b01);
    finish_cycle(s);
    s = idle();
    drive(s); #3;
    check("rb_rvalid", rvalid, 2'b01);
    check("rb_data", rdata, exp);
    finish_cycle(s);
  endtask

  // Starts a clear (with a simultaneous port-0 write), holds a port-1 read
  // request throughout, optionally re-pulses clear_start or aborts with Reset.
  task automatic clear_run(input logic [DW-1:0] val, input bit repulse, input bit abort,
                           input int exp_len);
    stim_t s;
    int    n_busy;
    int    guard;
    s = idle(); s.cs = 1'b1; s.cv = val; s.req = 2'b01; s.we = 2'b01; s.d0 = 8'h11;
    drive(s); #3;
    check("clr_start_gnt", gnt, 2'b01);
    check("clr_start_busy", clear_busy, 1'b0);
    finish_cycle(s);
    n_busy = 0;
    guard  = 0;
    while (guard < 60) begin
      if (!clear_busy && n_busy > 0) break;
      if (clear_busy) n_busy++;
      s = idle(); s.req = 2'b10; s.a1 = 4'h3;
      s.cs  = repulse && (n_busy == 6);
      s.cv  = 8'h77;
      s.rst = abort && (n_busy == 5);
      drive(s); #3;
      if (clear_busy && !s.rst) check("clr_stall", gnt, 2'b00);
      finish_cycle(s);
      guard++;
    end
    check("clr_done", clear_busy, 1'b0);
    check("clr_len", n_busy, exp_len);
  endtask

  vec_t  vec [10];
  stim_t st;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // dsp pce req we a0 a1 d0 | gnt rvalid rdata vid_valid
    vec[0] = '{1'b0, 1'b0, 2'b01, 2'b01, 4'hA, 4'h0, 8'hA5, 2'b01, 2'b00, 8'h00, 1'b0};
    vec[1] = '{1'b0, 1'b0, 2'b10, 2'b00, 4'h0, 4'hA, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0};
    vec[2] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 2'b00, 2'b10, 8'hA5, 1'b0};
    vec[3] = '{1'b0, 1'b0, 2'b11, 2'b00, 4'hA, 4'hA, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
    vec[4] = '{1'b0, 1'b0, 2'b11, 2'b00, 4'hA, 4'hA, 8'h00, 2'b10, 2'b01, 8'hA5, 1'b0};
    vec[5] = '{1'b0, 1'b0, 2'b11, 2'b00, 4'hA, 4'hA, 8'h00, 2'b01, 2'b10, 8'hA5, 1'b0};
    vec[6] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0};
    vec[7] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'hA, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
    vec[8] = '{1'b1, 1'b0, 2'b01, 2'b00, 4'hA, 4'h0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1};
    vec[9] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0};

    st = idle(); st.rst = 1'b1;
    drive(st);
    @(posedge Clk); #1;
    run_cycle(st);
    ram_init = 1'b0;
    run_cycle(st);

    st = idle();
    drive(st); #3;
    check("reset_gnt", gnt, 2'b00);
    check("reset_rvalid", rvalid, 2'b00);
    check("reset_vid_valid", vid_valid, 1'b0);
    check("reset_busy", clear_busy, 1'b0);
    check("reset_rdata", rdata, 8'h00);
    check("reset_vid_data", vid_data, 8'h00);
    finish_cycle(st);

    for (int i = 0; i < 10; i++) begin
      st = idle();
      st.dsp = vec[i].dsp; st.pce = vec[i].pce; st.vaddr = 4'hA;
      st.req = vec[i].req; st.we = vec[i].we; st.a0 = vec[i].a0; st.a1 = vec[i].a1;
      st.d0  = vec[i].d0;
      drive(st); #3;
      check($sformatf("vec%0d_gnt", i), gnt, vec[i].e_gnt);
      check($sformatf("vec%0d_rvalid", i), rvalid, vec[i].e_rv);
      check($sformatf("vec%0d_rdata", i), rdata, vec[i].e_rd);
      check($sformatf("vec%0d_vid_valid", i), vid_valid, vec[i].e_vv);
      finish_cycle(st);
    end

    // Active display with port 0 always requesting: grants only between pixels.
    begin
      logic prev_pce;
      prev_pce = 1'b0;
      for (int i = 0; i < 20; i++) begin
        st = idle();
        st.dsp = 1'b1; st.pce = (i % 2 == 0); st.vaddr = AW'(i);
        st.req = 2'b01; st.a0 = AW'(i + 3);
        drive(st); #3;
        check("act_gnt", gnt, st.pce ? 2'b00 : 2'b01);
        if (i > 0) check("act_vid_valid", vid_valid, prev_pce);
        prev_pce = st.pce;
        finish_cycle(st);
      end
    end

    clear_run(8'h3C, 1'b0, 1'b0, DEPTH);
    for (int i = 0; i < DEPTH; i++) readback(AW'(i), 8'h3C);

    clear_run(8'h5A, 1'b1, 1'b0, DEPTH);
    for (int i = 0; i < DEPTH; i++) readback(AW'(i), 8'h5A);

    for (int i = 0; i < DEPTH; i++) begin
      st = idle(); st.req = 2'b10; st.we = 2'b10; st.a1 = AW'(i); st.d1 = DW'(8'h80 + i);
      run_cycle(st);
    end
    clear_run(8'hC3, 1'b0, 1'b1, 5);
    for (int i = 0; i < DEPTH; i++) readback(AW'(i), (i < 4) ? 8'hC3 : DW'(8'h80 + i));

    // Randomized traffic; requesters hold their request until granted.
    begin
      bit            pend [2];
      logic          p_we [2];
      logic [AW-1:0] p_a  [2];
      logic [DW-1:0] p_d  [2];
      logic          dsp;
      logic [1:0]    g;
      pend[0] = 1'b0; pend[1] = 1'b0; dsp = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (i % 32 == 0) dsp = 1'($urandom_range(0, 1));
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
            pend[p] = 1'b1;
            p_we[p] = 1'($urandom_range(0, 1));
            p_a[p]  = AW'($urandom_range(0, DEPTH - 1));
            p_d[p]  = DW'($urandom_range(0, 255));
          end
        end
        st = idle();
        st.rst   = ($urandom_range(0, 199) == 0);
        st.dsp   = dsp;
        st.pce   = (i % 2 == 0);
        st.vaddr = AW'($urandom_range(0, DEPTH - 1));
        st.req   = {pend[1], pend[0]};
        st.we    = {p_we[1], p_we[0]};
        st.a0 = p_a[0]; st.a1 = p_a[1]; st.d0 = p_d[0]; st.d1 = p_d[1];
        st.cs    = ($urandom_range(0, 79) == 0);
        st.cv    = DW'($urandom_range(0, 255));
        drive(st); #3;
        g = gnt;
        finish_cycle(st);
        if (g[0]) pend[0] = 1'b0;
        if (g[1]) pend[1] = 1'b0;
      end
    end

    st = idle();
    run_cycle(st);
    for (int i = 0; i < DEPTH; i++) check($sformatf("ram_image%0d", i), ram[i], m_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
